// File: rtl/dmem_bridge.sv
// dmem_bridge: single-outstanding load/store bridge from the core LSU to a valid/ready memory port.
// Optional macro DMEM_TIMEOUT_EN aborts a BUSY transaction after TIMEOUT_CYCLES cycles without mem_ready.
module dmem_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic accept, finish, abort;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("dmem_bridge: TIMEOUT_CYCLES must be at least 1");
  end
  assign accept = state == IDLE && req_valid;
  assign finish = state == BUSY && mem_ready;
  assign stall  = accept || state == BUSY;
`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // Abort on the cycle the count would reach TIMEOUT_CYCLES, giving exactly that many BUSY cycles.
  assign abort = state == BUSY && !mem_ready && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (!rst_n || state != BUSY) cnt <= '0;
    else if (!mem_ready) cnt <= cnt + CW'(1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) err <= 1'b0;
    else err <= abort;
  end
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    state_nx = accept ? BUSY : (finish || abort) ? DONE : state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_valid   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      rdata_valid <= finish && mem_wstrb == 4'b0000;
      if (accept) begin
        mem_valid <= 1'b1;
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
        mem_wstrb <= req_we;
      end else if (finish || abort) begin
        mem_valid <= 1'b0;
      end
      if (finish && mem_wstrb == 4'b0000) rdata <= mem_rdata;
    end
  end
endmodule
